rc4_ksa_engine: RTL and testbench

//  Parametrised RC4 key-scheduling engine driving one single-port synchronous S-box RAM.

---
 rtl/rc4_ksa_engine.sv | 174 +++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of the S-box RAM, then the
// KSA swap loop, driving a single-port synchronous RAM with configurable read latency.
module rc4_ksa_engine #(
   parameter int N_BITS        = 8,
   parameter int MAX_KEY_BYTES = 3,
   parameter int RD_LAT        = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 skip_fill,
   input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]   key_len,
   input  logic [MAX_KEY_BYTES*N_BITS-1:0]      key,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err,
   output logic [N_BITS-1:0]                    address,
   output logic [N_BITS-1:0]                    ram_in,
   output logic                                 we,
   input  logic [N_BITS-1:0]                    ram_out
);

   localparam int              KLW       = $clog2(MAX_KEY_BYTES+1);
   localparam logic [KLW-1:0]  MAX_LEN   = KLW'(MAX_KEY_BYTES);
   localparam logic [1:0]      LAST_WAIT = 2'(RD_LAT-1);

   typedef enum logic [2:0] {IDLE, FILL, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J} state_t;

   state_t              state, state_n;
   logic                start_q;
   logic [KLW-1:0]      len_q, len_n, kidx, kidx_n;
   logic [N_BITS-1:0]   i, i_n, j, j_n, si, si_n, sj, sj_n;
   logic [1:0]          wcnt, wcnt_n;
   logic [N_BITS-1:0]   addr_n, din_n;
   logic                we_n, busy_n, done_n, err_n;
   logic                start_edge, len_ok;
   logic [N_BITS-1:0]   key_sym;

   assign start_edge = start & ~start_q;
   assign len_ok     = (key_len != '0) && (key_len <= MAX_LEN);
   assign key_sym    = key[kidx*N_BITS +: N_BITS];

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         start_q <= 1'b0;
         len_q   <= '0;
         kidx    <= '0;
         i       <= '0;
         j       <= '0;
         si      <= '0;
         sj      <= '0;
         wcnt    <= '0;
         address <= '0;
         ram_in  <= '0;
         we      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         start_q <= start;
         len_q   <= len_n;
         kidx    <= kidx_n;
         i       <= i_n;
         j       <= j_n;
         si      <= si_n;
         sj      <= sj_n;
         wcnt    <= wcnt_n;
         address <= addr_n;
         ram_in  <= din_n;
         we      <= we_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

   // RAM port values are derived from the state being entered, so address/we line up
   // with the cycle the FSM spends in FILL, RD_*, WR_* rather than lagging by one.
   always_comb begin
      state_n = state;
      len_n   = len_q;
      kidx_n  = kidx;
      i_n     = i;
      j_n     = j;
      si_n    = si;
      sj_n    = sj;
      wcnt_n  = wcnt;
      addr_n  = address;
      din_n   = ram_in;
      we_n    = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;

      case (state)
         IDLE: begin
            if (start_edge) begin
               if (len_ok) begin
                  len_n   = key_len;
                  i_n     = '0;
                  j_n     = '0;
                  kidx_n  = '0;
                  wcnt_n  = '0;
                  state_n = skip_fill ? RD_I : FILL;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         FILL: begin
            i_n = i + 1'b1;
            if (i == '1) state_n = RD_I;
         end
         RD_I: state_n = WT_I;
         WT_I: begin
            if (wcnt == LAST_WAIT) begin
               wcnt_n  = '0;
               si_n    = ram_out;
               j_n     = j + ram_out + key_sym;
               state_n = RD_J;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
         end
         RD_J: state_n = WT_J;
         WT_J: begin
            if (wcnt == LAST_WAIT) begin
               wcnt_n  = '0;
               sj_n    = ram_out;
               state_n = WR_I;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
         end
         WR_I: state_n = WR_J;
         WR_J: begin
            kidx_n = (kidx == len_q - 1'b1) ? '0 : kidx + 1'b1;
            i_n    = i + 1'b1;
            if (i == '1) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               state_n = RD_I;
            end
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         FILL: begin
            addr_n = i_n;
            din_n  = i_n;
            we_n   = 1'b1;
         end
         RD_I: addr_n = i_n;
         RD_J: addr_n = j_n;
         WR_I: begin
            addr_n = i;
            din_n  = sj_n;
            we_n   = 1'b1;
         end
         WR_J: begin
            addr_n = j;
            din_n  = si;
            we_n   = 1'b1;
         end
         default: ;
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: three instances (8-bit lat 1, 8-bit lat 2, 2-bit lat 1),
// each with its own RAM model, checked against a plain RC4 KSA reference.
module tb_rc4_ksa_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_v;
   logic        skip_fill;
   logic [1:0]  key_len;
   logic [23:0] key_v;
   logic        preload;
   int          sel;
   int          tests = 0;
   int          fails = 0;
   int          exp_s [256];

   logic        start_a, start_b, start_c;
   logic        busy_a, done_a, err_a, we_a;
   logic        busy_b, done_b, err_b, we_b;
   logic        busy_c, done_c, err_c, we_c;
   logic [7:0]  address_a, ram_in_a, ram_out_a, rd_a1;
   logic [7:0]  address_b, ram_in_b, ram_out_b, rd_b1, rd_b2;
   logic [1:0]  address_c, ram_in_c, ram_out_c, rd_c1;
   logic [7:0]  mem_a [256];
   logic [7:0]  mem_b [256];
   logic [1:0]  mem_c [4];
   logic        cur_busy, cur_done, cur_err, cur_we;

   always #5 clk = ~clk;

   assign start_a  = start_v && (sel == 0);
   assign start_b  = start_v && (sel == 1);
   assign start_c  = start_v && (sel == 2);
   assign cur_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
   assign cur_done = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
   assign cur_err  = (sel == 0) ? err_a  : (sel == 1) ? err_b  : err_c;
   assign cur_we   = (sel == 0) ? we_a   : (sel == 1) ? we_b   : we_c;

   rc4_ksa_engine #(.N_BITS(8), .MAX_KEY_BYTES(3), .RD_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .skip_fill(skip_fill), .key_len(key_len),
      .key(key_v), .busy(busy_a), .done(done_a), .err(err_a), .address(address_a),
      .ram_in(ram_in_a), .we(we_a), .ram_out(ram_out_a));

   rc4_ksa_engine #(.N_BITS(8), .MAX_KEY_BYTES(3), .RD_LAT(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .skip_fill(skip_fill), .key_len(key_len),
      .key(key_v), .busy(busy_b), .done(done_b), .err(err_b), .address(address_b),
      .ram_in(ram_in_b), .we(we_b), .ram_out(ram_out_b));

   rc4_ksa_engine #(.N_BITS(2), .MAX_KEY_BYTES(3), .RD_LAT(1)) dut_c (
      .clk(clk), .reset(reset), .start(start_c), .skip_fill(skip_fill), .key_len(key_len),
      .key(key_v[5:0]), .busy(busy_c), .done(done_c), .err(err_c), .address(address_c),
      .ram_in(ram_in_c), .we(we_c), .ram_out(ram_out_c));

   // Synchronous RAM models; preload forces the identity permutation in one cycle.
   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < 256; k++) begin
            mem_a[k] <= 8'(k);
            mem_b[k] <= 8'(k);
         end
      end else begin
         if (we_a) mem_a[address_a] <= ram_in_a;
         if (we_b) mem_b[address_b] <= ram_in_b;
      end
      if (we_c) mem_c[address_c] <= ram_in_c;
      rd_a1 <= mem_a[address_a];
      rd_b1 <= mem_b[address_b];
      rd_b2 <= rd_b1;
      rd_c1 <= mem_c[address_c];
   end

   assign ram_out_a = rd_a1;
   assign ram_out_b = rd_b2;
   assign ram_out_c = rd_c1;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Textbook RC4 KSA over an identity-initialised S of 2**nbits entries.
   task automatic model_ksa(input int nbits, input int klen, input logic [23:0] k);
      int depth, j, t, sym;
      depth = 1 << nbits;
      j = 0;
      for (int n = 0; n < depth; n++) exp_s[n] = n;
      for (int n = 0; n < depth; n++) begin
         sym = int'(k >> (nbits * (n % klen))) & (depth - 1);
         j = (j + exp_s[n] + sym) % depth;
         t = exp_s[n];
         exp_s[n] = exp_s[j];
         exp_s[j] = t;
      end
   endtask

   function automatic logic [31:0] ram_word(input int k);
      case (sel)
         0:       return 32'(mem_a[k]);
         1:       return 32'(mem_b[k]);
         default: return 32'(mem_c[k]);
      endcase
   endfunction

   task automatic check_ram(input string tag, input int depth);
      int bad;
      bad = 0;
      for (int k = 0; k < depth; k++)
         if (ram_word(k) !== 32'(exp_s[k])) bad++;
      check_output(tag, 32'(bad), 32'd0);
   endtask

   // Drives one start request on the selected instance and watches it to completion.
   task automatic apply_stimulus(input bit skip, input int klen, input int hold, input int second_edge,
                                 output int busy_n, output int done_n, output int err_n,
                                 output int stray_we, output int timed_out);
      busy_n = 0; done_n = 0; err_n = 0; stray_we = 0; timed_out = 1;
      skip_fill = skip;
      key_len   = 2'(klen);
      @(negedge clk);
      start_v = 1'b1;
      for (int cyc = 1; cyc <= 4000; cyc++) begin
         @(negedge clk);
         if (cyc == hold) start_v = 1'b0;
         if (second_edge > 0 && cyc == second_edge) start_v = 1'b1;
         if (second_edge > 0 && cyc == second_edge + 2) start_v = 1'b0;
         if (cur_busy) busy_n++;
         if (cur_done) done_n++;
         if (cur_err) err_n++;
         if (cur_we && !cur_busy) stray_we++;
         if (!cur_busy && cyc >= hold + 6 && (done_n > 0 || busy_n == 0)) begin
            timed_out = 0;
            break;
         end
      end
      start_v = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (cur_done) done_n++;
         if (cur_err) err_n++;
         if (cur_we) stray_we++;
      end
   endtask

   initial begin
      int busy_n, done_n, err_n, stray, tmo, klen, cnt_d, cnt_w;
      logic [1:0] small_exp [4];
      logic [23:0] rkey;

      reset = 1'b1; start_v = 1'b0; sel = 0; key_v = '0; key_len = 2'd1;
      skip_fill = 1'b0; preload = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset busy", 32'(busy_a), 32'd0);
      check_output("reset done", 32'(done_a), 32'd0);
      check_output("reset err", 32'(err_a), 32'd0);
      check_output("reset we", 32'(we_a), 32'd0);
      check_output("reset address", 32'(address_a), 32'd0);
      check_output("reset ram_in", 32'(ram_in_a), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 4-entry S-box, zero key of length 1
      sel = 2; key_v = '0;
      apply_stimulus(1'b0, 1, 1, 0, busy_n, done_n, err_n, stray, tmo);
      small_exp = '{2'd0, 2'd2, 2'd3, 2'd1};
      check_output("n2 timeout", 32'(tmo), 32'd0);
      check_output("n2 busy length", 32'(busy_n), 32'd28);
      check_output("n2 done count", 32'(done_n), 32'd1);
      for (int k = 0; k < 4; k++) check_output("n2 ram word", 32'(mem_c[k]), 32'(small_exp[k]));

      // "Key" on both latencies
      key_v = {8'h79, 8'h65, 8'h4B};
      model_ksa(8, 3, key_v);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         apply_stimulus(1'b0, 3, 1, 0, busy_n, done_n, err_n, stray, tmo);
         check_output("Key timeout", 32'(tmo), 32'd0);
         check_output("Key busy length", 32'(busy_n), (s == 0) ? 32'd1792 : 32'd2304);
         check_output("Key done count", 32'(done_n), 32'd1);
         check_output("Key err count", 32'(err_n), 32'd0);
         check_output("Key stray we", 32'(stray), 32'd0);
         check_ram("Key ram", 256);
      end

      // Illegal key lengths
      sel = 0;
      for (int l = 0; l < 2; l++) begin
         apply_stimulus(1'b0, (l == 0) ? 0 : 4, 1, 0, busy_n, done_n, err_n, stray, tmo);
         check_output("badlen err count", 32'(err_n), 32'd1);
         check_output("badlen busy", 32'(busy_n), 32'd0);
         check_output("badlen we", 32'(stray), 32'd0);
         check_output("badlen done", 32'(done_n), 32'd0);
      end

      // Skip fill on a preloaded identity RAM
      for (int s = 0; s < 2; s++) begin
         sel = s; key_v = '0;
         @(negedge clk); preload = 1'b1;
         @(negedge clk); preload = 1'b0;
         model_ksa(8, 1, key_v);
         apply_stimulus(1'b1, 1, 1, 0, busy_n, done_n, err_n, stray, tmo);
         check_output("skip busy length", 32'(busy_n), (s == 0) ? 32'd1536 : 32'd2048);
         check_output("skip done count", 32'(done_n), 32'd1);
         check_ram("skip ram", 256);
      end

      // Random key with a second start edge mid-run
      sel = 0; key_v = 24'($urandom); klen = $urandom_range(1, 3);
      model_ksa(8, klen, key_v);
      apply_stimulus(1'b0, klen, 1, 100, busy_n, done_n, err_n, stray, tmo);
      check_output("reedge busy length", 32'(busy_n), 32'd1792);
      check_output("reedge done count", 32'(done_n), 32'd1);
      check_output("reedge err count", 32'(err_n), 32'd0);
      check_ram("reedge ram", 256);

      // Reset in the middle of the swap loop
      skip_fill = 1'b0; key_len = 2'd2; key_v = 24'($urandom);
      @(negedge clk); start_v = 1'b1;
      @(negedge clk); start_v = 1'b0;
      repeat (600) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_output("midreset we", 32'(we_a), 32'd0);
      check_output("midreset busy", 32'(busy_a), 32'd0);
      check_output("midreset address", 32'(address_a), 32'd0);
      reset = 1'b0;
      cnt_d = 0; cnt_w = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_a) cnt_d++;
         if (we_a) cnt_w++;
      end
      check_output("midreset done", 32'(cnt_d), 32'd0);
      check_output("midreset writes", 32'(cnt_w), 32'd0);
      klen = $urandom_range(1, 3);
      model_ksa(8, klen, key_v);
      apply_stimulus(1'b0, klen, 1, 0, busy_n, done_n, err_n, stray, tmo);
      check_output("after reset done", 32'(done_n), 32'd1);
      check_ram("after reset ram", 256);

      // Start held high for 10 cycles, then further random runs
      for (int r = 0; r < 3; r++) begin
         sel = r % 2;
         rkey = 24'($urandom);
         key_v = rkey;
         klen = $urandom_range(1, 3);
         model_ksa(8, klen, rkey);
         apply_stimulus(1'b0, klen, (r == 0) ? 10 : 1, 0, busy_n, done_n, err_n, stray, tmo);
         check_output("rand timeout", 32'(tmo), 32'd0);
         check_output("rand done count", 32'(done_n), 32'd1);
         check_output("rand busy length", 32'(busy_n), (sel == 0) ? 32'd1792 : 32'd2304);
         check_ram("rand ram", 256);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
